// File: rtl/lc3_decode_ctrl_if.sv
// rtl/lc3_decode_ctrl_if.sv - instruction handshake, execute and fetch-control bundle for the LC3 decode stage
interface lc3_decode_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic [DATA_W-1:0] instr_in;
    logic              instr_ready;
    logic              exec_done;
    logic [3:0]        opCode_out;
    logic [8:0]        offset_out;
    logic [2:0]        br_nzp_out;
    logic              fetch_start;
    logic [2:0]        dr;
    logic [2:0]        sr1;
    logic [2:0]        sr2;
    logic              imm_sel;
    logic [4:0]        imm5;
    logic              exec_start;
    logic              busy;
    logic [CNT_W-1:0]  retired_cnt;
    logic              illegal_op;

    // Decoder side
    modport master (
        input  instr_valid, instr_in, exec_done,
        output instr_ready, opCode_out, offset_out, br_nzp_out, fetch_start,
               dr, sr1, sr2, imm_sel, imm5, exec_start, busy, retired_cnt, illegal_op
    );

    // Instruction memory / execute / fetch side
    modport slave (
        output instr_valid, instr_in, exec_done,
        input  instr_ready, opCode_out, offset_out, br_nzp_out, fetch_start,
               dr, sr1, sr2, imm_sel, imm5, exec_start, busy, retired_cnt, illegal_op
    );
endinterface

// File: rtl/lc3_decode_ctrl.sv
// rtl/lc3_decode_ctrl.sv - LC3 decode/sequence stage (optional DECODE_ILLEGAL_TRAP_EN traps opcode 1101)
module lc3_decode_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    lc3_decode_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] ir;
    logic              trap_q;
    logic              illegal_q;
    logic              instr_ready_q;
    logic              busy_q;
    logic              exec_start_q;
    logic              fetch_start_q;
    logic [CNT_W-1:0]  retired_q;
    logic              accept;
    logic              trap_in;

    assign accept = (state == S_IDLE) && bus.instr_valid && instr_ready_q;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign trap_in = (bus.instr_in[15:12] == 4'b1101);
`else
    assign trap_in = 1'b0;
`endif

    // Sequencer: IDLE -> DECODE -> EXEC -> ISSUE -> IDLE, trapped opcodes skip EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            ir            <= '0;
            trap_q        <= 1'b0;
            illegal_q     <= 1'b0;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            exec_start_q  <= 1'b0;
            fetch_start_q <= 1'b0;
            retired_q     <= '0;
        end else begin
            exec_start_q  <= 1'b0;
            fetch_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        ir            <= bus.instr_in;
                        trap_q        <= trap_in;
                        illegal_q     <= illegal_q | trap_in;
                        exec_start_q  <= ~trap_in;
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (trap_q) begin
                        fetch_start_q <= 1'b1;
                        state         <= S_ISSUE;
                    end else begin
                        state         <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (bus.exec_done) begin
                        fetch_start_q <= 1'b1;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    retired_q     <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Fields come straight from IR, so they change only when a new instruction is latched
    assign bus.opCode_out  = trap_q ? 4'b0000 : ir[15:12];
    assign bus.offset_out  = ir[8:0];
    assign bus.br_nzp_out  = (ir[15:12] == 4'b0000) ? ir[11:9] : 3'b000;
    assign bus.dr          = ir[11:9];
    assign bus.sr1         = ir[8:6];
    assign bus.sr2         = ir[2:0];
    assign bus.imm_sel     = ir[5];
    assign bus.imm5        = ir[4:0];
    assign bus.exec_start  = exec_start_q;
    assign bus.fetch_start = fetch_start_q;
    assign bus.instr_ready = instr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.retired_cnt = retired_q;
    assign bus.illegal_op  = illegal_q;

endmodule

// File: tb/tb_lc3_decode_ctrl.sv
// tb/tb_lc3_decode_ctrl.sv - directed self-checking bench for lc3_decode_ctrl
module tb_lc3_decode_ctrl;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    lc3_decode_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    lc3_decode_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    endtask

    // Present w at a falling edge once the decoder is ready; accepted on the following rising edge
    task automatic send(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        while (!bus.instr_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_send", bus.instr_ready, 1);
        bus.instr_valid = 1'b1;
        bus.instr_in    = w;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr_in    = 16'hFFFF;
    endtask

    // Full instruction: exec_done raised after wait_cyc EXEC cycles; early_done also pulses it during DECODE
    task automatic run_instr(input logic [15:0] w, input int wait_cyc, input bit early_done);
        bit bad = 0;
        send(w);
        @(negedge clk);
        chk("exec_start_c1", bus.exec_start, 1);
        chk("busy_c1", bus.busy, 1);
        chk("ready_c1", bus.instr_ready, 0);
        bus.exec_done = early_done;
        @(negedge clk);
        bus.exec_done = 1'b0;
        repeat (wait_cyc) begin
            if (bus.fetch_start || !bus.busy || bus.exec_start) bad = 1;
            @(negedge clk);
        end
        chk("exec_hold", bad, 0);
        chk("no_fs_before_done", bus.fetch_start, 0);
        bus.exec_done = 1'b1;
        @(negedge clk);
        bus.exec_done = 1'b0;
        chk("fetch_start", bus.fetch_start, 1);
        chk("busy_issue", bus.busy, 1);
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("fs_one_cycle", bus.fetch_start, 0);
        chk("ready_after", bus.instr_ready, 1);
        chk("idle_busy", bus.busy, 0);
        chk("retired_cnt", bus.retired_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit bad;
        bit pend;
        int n_fs;
        int n_es;
        bus.instr_valid = 1'b0;
        bus.instr_in    = 16'h0000;
        bus.exec_done   = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fs", bus.fetch_start, 0);
        chk("rst_es", bus.exec_start, 0);
        chk("rst_op", bus.opCode_out, 0);
        chk("rst_cnt", bus.retired_cnt, 0);
        chk("rst_illegal", bus.illegal_op, 0);

        // ADD R1,R2,R3 at minimum latency
        run_instr(16'h1283, 0, 1'b0);
        chk("add_op", bus.opCode_out, 4'b0001);
        chk("add_dr", bus.dr, 3'b001);
        chk("add_sr1", bus.sr1, 3'b010);
        chk("add_sr2", bus.sr2, 3'b011);
        chk("add_imm_sel", bus.imm_sel, 0);
        chk("add_nzp", bus.br_nzp_out, 3'b000);
        chk("add_off", bus.offset_out, 9'h083);

        // BRz with a long execute
        run_instr(16'h0405, 10, 1'b0);
        chk("brz_nzp", bus.br_nzp_out, 3'b010);
        chk("brz_off", bus.offset_out, 9'h005);
        chk("brz_op", bus.opCode_out, 4'b0000);

        // exec_done during DECODE is ignored
        run_instr(16'h1283, 2, 1'b1);

        // BR with nzp=000 decodes normally
        run_instr(16'h0003, 0, 1'b0);
        chk("br000_nzp", bus.br_nzp_out, 3'b000);
        chk("br000_off", bus.offset_out, 9'h003);

        // JMP R7, reset while in EXEC
        send(16'hC1C0);
        @(negedge clk);
        chk("jmp_op", bus.opCode_out, 4'hC);
        chk("jmp_sr1", bus.sr1, 3'b111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.instr_ready, 1);
        chk("arst_op", bus.opCode_out, 0);
        chk("arst_sr1", bus.sr1, 0);
        chk("arst_cnt", bus.retired_cnt, 0);
        exp_cnt = '0;
        bus.exec_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.exec_done = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.fetch_start || bus.busy || !bus.instr_ready) bad = 1;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_cnt", bus.retired_cnt, 0);

        // instr_valid held high: one accept per instruction, IR untouched while busy
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_in    = 16'h5020;
        pend = 0;
        n_fs = 0;
        n_es = 0;
        bad  = 0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            bus.exec_done = pend;
            pend = bus.exec_start;
            if (bus.exec_start) n_es++;
            if (bus.fetch_start) n_fs++;
            if (bus.dr != 3'b000 || bus.imm_sel != 1'b1 || bus.sr1 != 3'b000) bad = 1;
            bus.instr_in = bus.busy ? 16'h5FFF : 16'h5020;
            if (c == 39) bus.instr_valid = 1'b0;
        end
        bus.exec_done = 1'b0;
        chk("hold_ir_fields", bad, 0);
        chk("hold_exec_starts", n_es, 10);
        chk("hold_fetch_starts", n_fs, 10);
        exp_cnt = exp_cnt + 3'd2;
        @(negedge clk);
        chk("cnt_wrapped", bus.retired_cnt, exp_cnt);
        chk("hold_idle", bus.busy, 0);

        // Reserved opcode 1101
`ifdef DECODE_ILLEGAL_TRAP_EN
        send(16'hD000);
        @(negedge clk);
        chk("trap_illegal", bus.illegal_op, 1);
        chk("trap_no_es", bus.exec_start, 0);
        chk("trap_op", bus.opCode_out, 4'b0000);
        @(negedge clk);
        chk("trap_fs_c2", bus.fetch_start, 1);
        chk("trap_op_c2", bus.opCode_out, 4'b0000);
        chk("trap_nzp_c2", bus.br_nzp_out, 3'b000);
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk);
        chk("trap_ready", bus.instr_ready, 1);
        chk("trap_cnt", bus.retired_cnt, exp_cnt);
        run_instr(16'h1283, 0, 1'b0);
        chk("trap_sticky", bus.illegal_op, 1);
        chk("trap_next_op", bus.opCode_out, 4'b0001);
`else
        run_instr(16'hD000, 3, 1'b0);
        chk("d_op", bus.opCode_out, 4'hD);
        chk("d_illegal", bus.illegal_op, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
